dpdm_receiver: RTL and testbench

Device-to-host DP/DM line receiver. It replaces the pass-through read path in the DP/DM block. It samples the differential pair while the protocol FSM has the bus in read mode, captures one packet's raw line bits up to end-of-packet, and classifies the packet by bit length. It then replays the bits to the unencoding pipeline as a contiguous bitstream, tagged with the same packet-type code the writer consumes.

---
 rtl/dpdm_receiver.sv | 250 +++++++++++++++++++++++++
 tb/tb_dpdm_receiver.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpdm_receiver.sv
// -----------------------------------------------------------------------------
// dpdm_receiver
//
// Device-to-host DP/DM line receiver. While the bus is in read mode it
// captures one packet's raw line bits into a local buffer until end-of-packet
// (SE0, SE0, J). It then classifies the packet by its bit length and replays
// the bits as a contiguous bitstream, tagged with the packet type.
//
// Parameters:
//   TOK_BITS   line bits (sync included) in a token packet
//   DATA_BITS  line bits in a data packet
//   HS_BITS    line bits in a handshake packet
//   MAX_BITS   capture buffer depth (must be <= 127)
//
// Ports:
//   clk         system clock
//   rst_b       asynchronous active-low reset
//   rw          bus direction, 0 = read (receiver enabled), 1 = write
//   dp, dm      D+ / D- from the device (already synchronised)
//   bstr        replayed bitstream
//   bstr_ready  packet type while bstr is valid:
//               00 none, 01 token, 10 data, 11 handshake
//   rx_err      one-cycle error pulse
//   busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dpdm_receiver #(
    parameter int TOK_BITS  = 32,
    parameter int DATA_BITS = 92,
    parameter int HS_BITS   = 12,
    parameter int MAX_BITS  = 96
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       rw,
    input  logic       dp,
    input  logic       dm,
    output logic       bstr,
    output logic [1:0] bstr_ready,
    output logic       rx_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        L_SE0 = 2'b00,
        L_K   = 2'b01,
        L_J   = 2'b10,
        L_SE1 = 2'b11
    } line_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_EOP1,
        S_EOP2,
        S_REPLAY,
        S_DRAIN
    } state_e;

    localparam logic [6:0] TOK_C  = 7'(TOK_BITS);
    localparam logic [6:0] DATA_C = 7'(DATA_BITS);
    localparam logic [6:0] HS_C   = 7'(HS_BITS);
    localparam logic [6:0] MAX_C  = 7'(MAX_BITS);

    line_e line;
    assign line = line_e'({dp, dm});

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] rd_q, rd_d;
    logic [1:0] type_q, type_d;
    logic       ovr_q, ovr_d;      // K seen on the line during replay
    logic       bstr_q, bstr_d;
    logic [1:0] ready_q, ready_d;
    logic       rx_err_q, rx_err_d;
    logic       busy_q, busy_d;

    logic       buf_q [MAX_BITS];
    logic       buf_we;
    logic [6:0] buf_wa;
    logic       buf_wd;

    logic [1:0] match_type;
    logic       k_seen;

    // Packet type implied by the captured length; 00 means no match.
    always_comb begin
        match_type = 2'b00;
        if (cnt_q == TOK_C) begin
            match_type = 2'b01;
        end else if (cnt_q == DATA_C) begin
            match_type = 2'b10;
        end else if (cnt_q == HS_C) begin
            match_type = 2'b11;
        end
    end

    assign k_seen = !rw && (line == L_K);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        type_d   = type_q;
        ovr_d    = ovr_q;
        bstr_d   = 1'b0;
        ready_d  = 2'b00;
        rx_err_d = 1'b0;
        buf_we   = 1'b0;
        buf_wa   = cnt_q;
        buf_wd   = dp;

        unique case (state_q)
            S_IDLE: begin
                ovr_d = 1'b0;
                if (k_seen) begin
                    buf_we  = 1'b1;
                    buf_wa  = 7'd0;
                    cnt_d   = 7'd1;
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (rw) begin
                    state_d = S_IDLE;
                end else begin
                    unique case (line)
                        L_J, L_K: begin
                            if (cnt_q == MAX_C) begin
                                rx_err_d = 1'b1;
                                state_d  = S_DRAIN;
                            end else begin
                                buf_we = 1'b1;
                                cnt_d  = cnt_q + 7'd1;
                            end
                        end
                        L_SE0: state_d = S_EOP1;
                        L_SE1: begin
                            rx_err_d = 1'b1;
                            state_d  = S_DRAIN;
                        end
                    endcase
                end
            end

            S_EOP1: begin
                if (rw) begin
                    state_d = S_IDLE;
                end else if (line == L_SE0) begin
                    state_d = S_EOP2;
                end else begin
                    rx_err_d = 1'b1;
                    state_d  = S_DRAIN;
                end
            end

            S_EOP2: begin
                if (rw) begin
                    state_d = S_IDLE;
                end else if (line == L_J) begin
                    if (match_type != 2'b00) begin
                        // First bit goes out on this edge so it appears the
                        // cycle after the terminating J.
                        type_d  = match_type;
                        bstr_d  = buf_q[0];
                        ready_d = match_type;
                        rd_d    = 7'd1;
                        ovr_d   = 1'b0;
                        state_d = (cnt_q == 7'd1) ? S_IDLE : S_REPLAY;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    rx_err_d = 1'b1;
                    state_d  = S_DRAIN;
                end
            end

            S_REPLAY: begin
                bstr_d  = buf_q[rd_q];
                ready_d = type_q;
                rd_d    = rd_q + 7'd1;
                ovr_d   = ovr_q | k_seen;
                // Leave on the edge that loads the last bit, so a K in the
                // following cycle is sampled by IDLE as a new start.
                if (rd_q == cnt_q - 7'd1) begin
                    state_d = (ovr_q || k_seen) ? S_DRAIN : S_IDLE;
                end
            end

            S_DRAIN: begin
                // Overrun error is reported one cycle after the last bit.
                if (ovr_q) begin
                    rx_err_d = 1'b1;
                    ovr_d    = 1'b0;
                end
                if (!rw && line == L_J) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= 7'd0;
            rd_q     <= 7'd0;
            type_q   <= 2'b00;
            ovr_q    <= 1'b0;
            bstr_q   <= 1'b0;
            ready_q  <= 2'b00;
            rx_err_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            type_q   <= type_d;
            ovr_q    <= ovr_d;
            bstr_q   <= bstr_d;
            ready_q  <= ready_d;
            rx_err_q <= rx_err_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: the capture buffer is deliberately not reset; it is only read
    // back after being written, so resetting it would just cost logic.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_wa] <= buf_wd;
        end
    end

    assign bstr       = bstr_q;
    assign bstr_ready = ready_q;
    assign rx_err     = rx_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dpdm_receiver.sv
// -----------------------------------------------------------------------------
// tb_dpdm_receiver
//
// Directed testbench for dpdm_receiver. Inputs change and outputs are
// checked on the falling clock edge; the DUT samples on the rising edge.
// -----------------------------------------------------------------------------
module tb_dpdm_receiver;

    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_J   = 2'b10;

    localparam logic [127:0] PAT_HS   = 128'h0000_0000_0000_0000_0000_0000_0000_0B36;
    localparam logic [127:0] PAT_DATA = 128'hC3A5_9E71_0F2D_B486_5A3C_E19B_7D24_6F58;
    localparam logic [127:0] PAT_TOK  = 128'h0000_0000_0000_0000_0000_0000_8E3D_59A6;
    localparam logic [127:0] PAT_ODD  = 128'h0000_0000_0000_0000_0000_0000_000A_B5C2;
    localparam logic [127:0] PAT_LONG = 128'hFFFF_FFFF_6B1D_27E4_93CA_0F5E_D286_17B4;

    logic       clk;
    logic       rst_b;
    logic       rw;
    logic       dp;
    logic       dm;
    logic       bstr;
    logic [1:0] bstr_ready;
    logic       rx_err;
    logic       busy;

    int checks;
    int errors;

    dpdm_receiver dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .rw         (rw),
        .dp         (dp),
        .dm         (dm),
        .bstr       (bstr),
        .bstr_ready (bstr_ready),
        .rx_err     (rx_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a line symbol, then advance to the next falling edge, where
    // the outputs reflect the DUT's reaction to that symbol.
    task automatic drive(input logic [1:0] sym);
        {dp, dm} = sym;
        @(negedge clk);
    endtask

    // K start bit followed by bits 1..n-1 of the pattern.
    task automatic send_bits(input int n, input logic [127:0] p);
        drive(SYM_K);
        for (int i = 1; i < n; i++) begin
            drive(p[i] ? SYM_J : SYM_K);
        end
    endtask

    task automatic send_eop();
        drive(SYM_SE0);
        drive(SYM_SE0);
        drive(SYM_J);
    endtask

    // Called at the falling edge where the first replayed bit is visible.
    // Returns at the edge where the last bit is visible.
    task automatic check_replay(input string name, input int n, input logic [1:0] typ,
                                input logic [127:0] p, input bit inject_k);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bstr_ready !== typ) begin
                errors++;
                $display("FAIL %s ready[%0d]: got %b expected %b", name, i, bstr_ready, typ);
            end
            checks++;
            if (bstr !== p[i]) begin
                errors++;
                $display("FAIL %s bstr[%0d]: got %b expected %b", name, i, bstr, p[i]);
            end
            checks++;
            if (rx_err !== 1'b0) begin
                errors++;
                $display("FAIL %s rx_err[%0d]: got %b expected 0", name, i, rx_err);
            end
            if (i < n - 1) begin
                drive((inject_k && i == 2) ? SYM_K : SYM_J);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bstr, bstr_ready, rx_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_held: got bstr=%b ready=%b err=%b busy=%b expected all 0",
                     bstr, bstr_ready, rx_err, busy);
        end
        rst_b = 1'b1;
        drive(SYM_J);
        checks++;
        if ({bstr, bstr_ready, rx_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle: got bstr=%b ready=%b err=%b busy=%b expected all 0",
                     bstr, bstr_ready, rx_err, busy);
        end
    endtask

    task automatic test_handshake();
        drive(SYM_K);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hs_busy_rise: got %b expected 1", busy);
        end
        for (int i = 1; i < 12; i++) begin
            drive(PAT_HS[i] ? SYM_J : SYM_K);
        end
        send_eop();
        check_replay("hs", 12, 2'b11, PAT_HS, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_busy_fall: got %b expected 0", busy);
        end
        drive(SYM_J);
        checks++;
        if (bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL hs_ready_end: got %b expected 00", bstr_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_bits(92, PAT_DATA);
        send_eop();
        check_replay("data", 92, 2'b10, PAT_DATA, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_gap: got %b expected 0", busy);
        end
        // K presented in the very next cycle must start a new packet.
        drive(SYM_K);
        checks++;
        if (busy !== 1'b1 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b ready=%b expected busy=1 ready=00",
                     busy, bstr_ready);
        end
        for (int i = 1; i < 32; i++) begin
            drive(PAT_TOK[i] ? SYM_J : SYM_K);
        end
        send_eop();
        check_replay("tok", 32, 2'b01, PAT_TOK, 1'b0);
        drive(SYM_J);
        checks++;
        if (bstr_ready !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tok_end: got ready=%b busy=%b expected 00 0", bstr_ready, busy);
        end
    endtask

    task automatic test_bad_length();
        send_bits(20, PAT_ODD);
        send_eop();
        checks++;
        if (rx_err !== 1'b1 || bstr_ready !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badlen_err: got err=%b ready=%b busy=%b expected 1 00 0",
                     rx_err, bstr_ready, busy);
        end
        drive(SYM_J);
        checks++;
        if (rx_err !== 1'b0 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL badlen_after: got err=%b ready=%b expected 0 00", rx_err, bstr_ready);
        end
    endtask

    task automatic test_bad_eop();
        send_bits(10, PAT_ODD);
        drive(SYM_SE0);
        drive(SYM_K);
        checks++;
        if (rx_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL badeop_err: got err=%b busy=%b expected 1 1", rx_err, busy);
        end
        drive(SYM_K);
        checks++;
        if (rx_err !== 1'b0 || busy !== 1'b1 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL badeop_drain: got err=%b busy=%b ready=%b expected 0 1 00",
                     rx_err, busy, bstr_ready);
        end
        drive(SYM_J);
        checks++;
        if (busy !== 1'b0 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL badeop_exit: got busy=%b ready=%b expected 0 00", busy, bstr_ready);
        end
    endtask

    task automatic test_overflow();
        drive(SYM_K);
        for (int i = 1; i < 97; i++) begin
            drive(PAT_LONG[i] ? SYM_J : SYM_K);
            if (i == 95) begin
                checks++;
                if (rx_err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_full: got err=%b busy=%b expected 0 1", rx_err, busy);
                end
            end
        end
        checks++;
        if (rx_err !== 1'b1 || bstr_ready !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_err: got err=%b ready=%b busy=%b expected 1 00 1",
                     rx_err, bstr_ready, busy);
        end
        drive(SYM_SE0);
        checks++;
        if (rx_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain: got err=%b busy=%b expected 0 1", rx_err, busy);
        end
        drive(SYM_J);
        checks++;
        if (busy !== 1'b0 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL ovf_exit: got busy=%b ready=%b expected 0 00", busy, bstr_ready);
        end
    endtask

    task automatic test_rw_abort();
        send_bits(10, PAT_HS);
        rw = 1'b1;
        drive(SYM_J);
        checks++;
        if (busy !== 1'b0 || rx_err !== 1'b0) begin
            errors++;
            $display("FAIL abort: got busy=%b err=%b expected 0 0", busy, rx_err);
        end
        rw = 1'b0;
        drive(SYM_J);
        checks++;
        if (busy !== 1'b0 || rx_err !== 1'b0 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL abort_after: got busy=%b err=%b ready=%b expected 0 0 00",
                     busy, rx_err, bstr_ready);
        end
    endtask

    task automatic test_overrun();
        send_bits(12, PAT_HS);
        send_eop();
        check_replay("ovr", 12, 2'b11, PAT_HS, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drain: got busy=%b expected 1", busy);
        end
        drive(SYM_J);
        checks++;
        if (rx_err !== 1'b1 || busy !== 1'b0 || bstr_ready !== 2'b00) begin
            errors++;
            $display("FAIL ovr_err: got err=%b busy=%b ready=%b expected 1 0 00",
                     rx_err, busy, bstr_ready);
        end
        drive(SYM_J);
        checks++;
        if (rx_err !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pulse: got err=%b expected 0", rx_err);
        end
    endtask

    task automatic test_reset_mid_replay();
        send_bits(12, PAT_HS);
        send_eop();
        drive(SYM_J);
        drive(SYM_J);
        checks++;
        if (bstr_ready !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre: got ready=%b expected 11", bstr_ready);
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (bstr_ready !== 2'b00 || busy !== 1'b0 || bstr !== 1'b0 || rx_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got ready=%b busy=%b bstr=%b err=%b expected 00 0 0 0",
                     bstr_ready, busy, bstr, rx_err);
        end
        @(negedge clk);
        rst_b = 1'b1;
        drive(SYM_J);
        drive(SYM_J);
        checks++;
        if (bstr_ready !== 2'b00 || busy !== 1'b0 || rx_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got ready=%b busy=%b err=%b expected 00 0 0",
                     bstr_ready, busy, rx_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        rw     = 1'b0;
        {dp, dm} = SYM_J;
        repeat (2) @(negedge clk);

        test_reset();
        test_handshake();
        test_back_to_back();
        test_bad_length();
        test_bad_eop();
        test_overflow();
        test_rw_abort();
        test_overrun();
        test_reset_mid_replay();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
